// File: rtl/sw_led_ctrl.sv
// Switch debouncer and LED pattern generator: synchronizes and debounces the
// switch inputs, then drives the LEDs as mirror, blink, count or chase.
module sw_led_ctrl #(
  parameter int unsigned N_SW     = 2,
  parameter int unsigned N_LED    = 4,
  parameter int unsigned DB_CYC   = 1000,
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic [N_SW-1:0]  sw_stable
);

  localparam int unsigned CNT_W = $clog2(DB_CYC);
  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_MIRROR = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  // Synchronizer and debounce state
  logic [N_SW-1:0]  sw_meta;
  logic [N_SW-1:0]  sw_sync;
  logic [CNT_W-1:0] db_cnt     [N_SW];
  logic [CNT_W-1:0] db_cnt_nxt [N_SW];
  logic [N_SW-1:0]  stable_nxt;

  // Pattern state
  mode_e            mode_q;
  mode_e            mode_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             phase;
  logic             phase_nxt;
  logic [N_LED-1:0] value;
  logic [N_LED-1:0] value_nxt;
  logic [N_LED-1:0] pos;
  logic [N_LED-1:0] pos_nxt;
  logic [N_LED-1:0] led_nxt;
  logic [N_LED-1:0] mirror;

  logic             tick;
  logic             mode_chg;
  logic             rise0;

  localparam logic [N_LED-1:0] POS_INIT = N_LED'(1);

  // Two-flop synchronizer for the raw switch levels
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Debounce: a level must differ for DB_CYC consecutive cycles to be accepted
  always_comb begin
    stable_nxt = sw_stable;
    for (int i = 0; i < int'(N_SW); i++) begin
      db_cnt_nxt[i] = '0;
      if (sw_sync[i] != sw_stable[i]) begin
        if (db_cnt[i] == CNT_W'(DB_CYC - 1)) begin
          stable_nxt[i] = sw_sync[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce counters and accepted switch levels
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SW); i++) begin
        db_cnt[i] <= '0;
      end
      sw_stable <= '0;
    end else begin
      for (int i = 0; i < int'(N_SW); i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
      sw_stable <= stable_nxt;
    end
  end

  // Mirror pattern repeats the switch vector across all LEDs
  for (genvar g = 0; g < int'(N_LED); g++) begin : g_mirror
    assign mirror[g] = sw_stable[g % N_SW];
  end

  assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign mode_chg = (mode != 2'(mode_q));
  assign rise0    = stable_nxt[0] & ~sw_stable[0];

  // Next-state and LED pattern; a mode change restarts every pattern source
  always_comb begin
    mode_nxt  = mode_e'(mode);
    div_nxt   = tick ? '0 : div_cnt + DIV_W'(1);
    phase_nxt = phase;
    value_nxt = value;
    pos_nxt   = pos;
    led_nxt   = '0;

    if (tick && mode_q == MODE_BLINK) begin
      phase_nxt = ~phase;
    end

    if (rise0 && mode_q == MODE_COUNT) begin
      value_nxt = value + N_LED'(1);
    end

    if (tick && mode_q == MODE_CHASE) begin
      if (sw_stable[1]) begin
        pos_nxt = {pos[0], pos[N_LED-1:1]};
      end else begin
        pos_nxt = {pos[N_LED-2:0], pos[N_LED-1]};
      end
    end

    if (mode_chg) begin
      div_nxt   = '0;
      phase_nxt = 1'b0;
      value_nxt = '0;
      pos_nxt   = POS_INIT;
    end

    case (mode_q)
      MODE_MIRROR: led_nxt = mirror;
      MODE_BLINK:  led_nxt = mirror & {N_LED{phase}};
      MODE_COUNT:  led_nxt = value;
      MODE_CHASE:  led_nxt = pos;
      default:     led_nxt = '0;
    endcase
  end

  // Pattern state and registered LED drive
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_MIRROR;
      div_cnt <= '0;
      phase   <= 1'b0;
      value   <= '0;
      pos     <= POS_INIT;
      led     <= '0;
    end else begin
      mode_q  <= mode_nxt;
      div_cnt <= div_nxt;
      phase   <= phase_nxt;
      value   <= value_nxt;
      pos     <= pos_nxt;
      led     <= led_nxt;
    end
  end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl with short debounce and tick periods.
module tb_sw_led_ctrl;

  logic       sysclk;
  logic       rst_n;
  logic [1:0] sw;
  logic [1:0] mode;
  logic [3:0] led;
  logic [1:0] sw_stable;

  int n_vec;
  int n_err;

  sw_led_ctrl #(
    .N_SW    (2),
    .N_LED   (4),
    .DB_CYC  (4),
    .TICK_DIV(8)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .sw       (sw),
    .mode     (mode),
    .led      (led),
    .sw_stable(sw_stable)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sw    = 2'b00;
    mode  = 2'd0;

    // Reset state
    step(3);
    chk("rst_led", 8'(led), 8'h0);
    chk("rst_stable", 8'(sw_stable), 8'h0);
    rst_n = 1'b1;
    step(3);

    // Mirror: exact debounce latency
    sw = 2'b01;
    step(5);
    chk("mir_stable_e5", 8'(sw_stable), 8'h0);
    step(1);
    chk("mir_stable_e6", 8'(sw_stable), 8'h1);
    chk("mir_led_e6", 8'(led), 8'h0);
    step(1);
    chk("mir_led_e7", 8'(led), 8'h5);
    sw = 2'b10;
    step(10);
    chk("mir_led_10", 8'(led), 8'hA);
    sw = 2'b11;
    step(10);
    chk("mir_led_11", 8'(led), 8'hF);
    sw = 2'b00;
    step(10);
    chk("mir_led_00", 8'(led), 8'h0);

    // Bounce shorter than the debounce window is ignored
    sw = 2'b01;
    step(3);
    sw = 2'b00;
    step(10);
    chk("bounce_stable", 8'(sw_stable), 8'h0);
    chk("bounce_led", 8'(led), 8'h0);

    // Reset mid-debounce discards the partial count
    sw = 2'b01;
    step(4);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("rstdb_e5", 8'(sw_stable), 8'h0);
    step(1);
    chk("rstdb_e6", 8'(sw_stable), 8'h1);

    // Blink with both switches on
    sw = 2'b11;
    step(10);
    mode = 2'd1;
    step(1);
    chk("blink_e0", 8'(led), 8'hF);
    step(1);
    chk("blink_e1", 8'(led), 8'h0);
    step(7);
    chk("blink_e8", 8'(led), 8'h0);
    step(1);
    chk("blink_e9", 8'(led), 8'hF);
    step(7);
    chk("blink_e16", 8'(led), 8'hF);
    step(1);
    chk("blink_e17", 8'(led), 8'h0);

    // Count presses of sw[0], including wrap
    sw = 2'b00;
    step(10);
    mode = 2'd2;
    step(2);
    chk("count_start", 8'(led), 8'h0);
    for (int p = 1; p <= 17; p++) begin
      sw = 2'b01;
      step(8);
      sw = 2'b00;
      step(8);
      if (p == 1)  chk("count_1", 8'(led), 8'h1);
      if (p == 2)  chk("count_2", 8'(led), 8'h2);
      if (p == 16) chk("count_16", 8'(led), 8'h0);
      if (p == 17) chk("count_17", 8'(led), 8'h1);
    end

    // Mode change 2 -> 3 -> 2 restarts the count value
    mode = 2'd3;
    step(1);
    mode = 2'd2;
    step(3);
    chk("count_restart", 8'(led), 8'h0);
    sw = 2'b01;
    step(8);
    sw = 2'b00;
    step(8);
    chk("count_after_restart", 8'(led), 8'h1);

    // Chase upward
    mode = 2'd3;
    step(2);
    chk("chase_up0", 8'(led), 8'h1);
    step(8);
    chk("chase_up1", 8'(led), 8'h2);
    step(8);
    chk("chase_up2", 8'(led), 8'h4);
    step(8);
    chk("chase_up3", 8'(led), 8'h8);
    step(8);
    chk("chase_up4", 8'(led), 8'h1);

    // Chase downward once sw[1] is debounced high
    sw = 2'b10;
    step(10);
    chk("chase_dir_stable", 8'(sw_stable), 8'h2);
    mode = 2'd0;
    step(1);
    mode = 2'd3;
    step(2);
    chk("chase_dn0", 8'(led), 8'h1);
    step(8);
    chk("chase_dn1", 8'(led), 8'h8);
    step(8);
    chk("chase_dn2", 8'(led), 8'h4);

    // Asynchronous reset mid-chase, then chase restarts
    step(3);
    rst_n = 1'b0;
    #1;
    chk("chase_rst_led", 8'(led), 8'h0);
    chk("chase_rst_stable", 8'(sw_stable), 8'h0);
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("chase_rel_e1", 8'(led), 8'h0);
    step(1);
    chk("chase_rel_e2", 8'(led), 8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
